// File: rtl/instr_assembler.sv
// instr_assembler: gathers an opcode byte and its immediates from a byte stream into one instruction
module instr_assembler #(
  parameter int DATA_W  = 8,
  parameter int MAX_IMM = 3,
  parameter int LEN_W   = 3,
  parameter int CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_W-1:0]             out_opcode,
  output logic [MAX_IMM*DATA_W-1:0]     out_imm,
  output logic [$clog2(MAX_IMM+1)-1:0]  out_imm_count,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic [CNT_W-1:0]              retired
);
  localparam int IMM_CW = $clog2(MAX_IMM+1);
  typedef enum logic [1:0] {IDLE, GATHER, HOLD} state_t;
  state_t state, state_nx;
  logic [IMM_CW-1:0] cnt, n, n_new;
  logic [LEN_W-1:0] len;
  logic [MAX_IMM-1:0][DATA_W-1:0] imm;
  logic xfer, retire, op_xfer, last;
  assign len           = in_data[DATA_W-1 -: LEN_W];
  assign n_new         = (int'(len) > MAX_IMM) ? IMM_CW'(MAX_IMM) : IMM_CW'(len);
  assign out_valid     = state == HOLD;
  assign busy          = state == GATHER;
  assign in_ready      = !out_valid || out_ready;
  assign xfer          = in_valid && in_ready;
  assign retire        = out_valid && out_ready;
  // in HOLD a transfer can only happen alongside a retire, so the byte is a fresh opcode
  assign op_xfer       = xfer && (state == IDLE || state == HOLD);
  assign last          = busy && xfer && cnt == n - 1'b1;
  assign out_imm_count = out_valid ? n : '0;
  assign out_imm       = imm;
  // next state: flush wins, then opcode arrival, then last immediate, then plain retire
  always_comb begin
    state_nx = flush ? IDLE :
               op_xfer ? (n_new == '0 ? HOLD : GATHER) :
               last ? HOLD :
               retire ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : state_nx;
  end
  // datapath: opcode/immediate capture, byte index and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      n          <= '0;
      out_opcode <= '0;
      imm        <= '0;
      retired    <= '0;
    end else begin
      if (retire) retired <= retired + 1'b1;
      if (flush) cnt <= '0;
      else if (op_xfer) begin
        out_opcode <= in_data;
        imm        <= '0;
        n          <= n_new;
        cnt        <= '0;
      end else if (busy && xfer) begin
        for (int k = 0; k < MAX_IMM; k++)
          if (cnt == IMM_CW'(k)) imm[k] <= in_data;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_assembler.sv
// tb_instr_assembler: directed vector table plus hand sequences for clamp and counter wrap
module tb_instr_assembler;
  logic clk = 0, reset, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic in_ready, out_valid, busy;
  logic [7:0] out_opcode;
  logic [23:0] out_imm;
  logic [1:0] out_imm_count;
  logic [15:0] retired;
  logic in_ready2, out_valid2, busy2;
  logic [7:0] out_opcode2, out_imm2;
  logic out_imm_count2;
  logic [15:0] retired2;
  logic in_ready3, out_valid3, busy3;
  logic [7:0] out_opcode3;
  logic [23:0] out_imm3;
  logic [1:0] out_imm_count3;
  logic [3:0] retired3;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  instr_assembler dut (
    .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_opcode(out_opcode), .out_imm(out_imm), .out_imm_count(out_imm_count),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .retired(retired));

  instr_assembler #(.MAX_IMM(1)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready2), .out_opcode(out_opcode2), .out_imm(out_imm2), .out_imm_count(out_imm_count2),
    .out_valid(out_valid2), .out_ready(out_ready), .busy(busy2), .retired(retired2));

  instr_assembler #(.CNT_W(4)) dut3 (
    .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready3), .out_opcode(out_opcode3), .out_imm(out_imm3), .out_imm_count(out_imm_count3),
    .out_valid(out_valid3), .out_ready(out_ready), .busy(busy3), .retired(retired3));

  typedef struct {
    logic rst, fl, iv;
    logic [7:0] d;
    logic ordy;
    logic ir, ov, bz;
    logic [7:0] op;
    logic [23:0] imm;
    logic [1:0] cnt;
    logic [15:0] ret;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic v, input logic [7:0] d, input logic o);
    reset = r; flush = f; in_valid = v; in_data = d; out_ready = o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        rst fl iv data    ordy ir ov bz op       imm         cnt   ret
    vq.push_back('{1, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 24'h000000, 2'd0, 16'd0});
    vq.push_back('{0, 0, 1, 8'h40, 1, 1, 0, 1, 8'h40, 24'h000000, 2'd0, 16'd0});
    vq.push_back('{0, 0, 1, 8'hAA, 1, 1, 0, 1, 8'h40, 24'h0000AA, 2'd0, 16'd0});
    vq.push_back('{0, 0, 1, 8'hBB, 1, 1, 1, 0, 8'h40, 24'h00BBAA, 2'd2, 16'd0});
    vq.push_back('{0, 0, 0, 8'h00, 1, 1, 0, 0, 8'h40, 24'h00BBAA, 2'd0, 16'd1});
    vq.push_back('{1, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 24'h000000, 2'd0, 16'd0});
    vq.push_back('{0, 0, 1, 8'h01, 1, 1, 1, 0, 8'h01, 24'h000000, 2'd0, 16'd0});
    vq.push_back('{0, 0, 1, 8'h02, 1, 1, 1, 0, 8'h02, 24'h000000, 2'd0, 16'd1});
    vq.push_back('{0, 0, 1, 8'h03, 1, 1, 1, 0, 8'h03, 24'h000000, 2'd0, 16'd2});
    vq.push_back('{0, 0, 0, 8'h00, 1, 1, 0, 0, 8'h03, 24'h000000, 2'd0, 16'd3});
    vq.push_back('{0, 0, 1, 8'h60, 0, 1, 0, 1, 8'h60, 24'h000000, 2'd0, 16'd3});
    vq.push_back('{0, 0, 1, 8'h11, 0, 1, 0, 1, 8'h60, 24'h000011, 2'd0, 16'd3});
    vq.push_back('{0, 0, 1, 8'h22, 0, 1, 0, 1, 8'h60, 24'h002211, 2'd0, 16'd3});
    vq.push_back('{0, 0, 1, 8'h33, 0, 0, 1, 0, 8'h60, 24'h332211, 2'd3, 16'd3});
    vq.push_back('{0, 0, 1, 8'h44, 0, 0, 1, 0, 8'h60, 24'h332211, 2'd3, 16'd3});
    vq.push_back('{0, 0, 1, 8'h44, 0, 0, 1, 0, 8'h60, 24'h332211, 2'd3, 16'd3});
    vq.push_back('{0, 0, 1, 8'h00, 1, 1, 1, 0, 8'h00, 24'h000000, 2'd0, 16'd4});
    vq.push_back('{0, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 24'h000000, 2'd0, 16'd5});
    vq.push_back('{0, 0, 1, 8'h60, 1, 1, 0, 1, 8'h60, 24'h000000, 2'd0, 16'd5});
    vq.push_back('{0, 0, 1, 8'h11, 1, 1, 0, 1, 8'h60, 24'h000011, 2'd0, 16'd5});
    vq.push_back('{0, 1, 0, 8'h00, 1, 1, 0, 0, 8'h60, 24'h000011, 2'd0, 16'd5});
    vq.push_back('{0, 0, 1, 8'h00, 1, 1, 1, 0, 8'h00, 24'h000000, 2'd0, 16'd5});
    vq.push_back('{0, 1, 1, 8'h20, 1, 1, 0, 0, 8'h00, 24'h000000, 2'd0, 16'd6});
    vq.push_back('{0, 1, 1, 8'h20, 1, 1, 0, 0, 8'h00, 24'h000000, 2'd0, 16'd6});
    vq.push_back('{0, 0, 1, 8'h20, 1, 1, 0, 1, 8'h20, 24'h000000, 2'd0, 16'd6});
    vq.push_back('{1, 0, 1, 8'hAA, 1, 1, 0, 0, 8'h00, 24'h000000, 2'd0, 16'd0});
    vq.push_back('{0, 0, 1, 8'hE0, 1, 1, 0, 1, 8'hE0, 24'h000000, 2'd0, 16'd0});
    vq.push_back('{0, 0, 1, 8'h01, 1, 1, 0, 1, 8'hE0, 24'h000001, 2'd0, 16'd0});
    vq.push_back('{0, 0, 1, 8'h02, 1, 1, 0, 1, 8'hE0, 24'h000201, 2'd0, 16'd0});
    vq.push_back('{0, 0, 1, 8'h03, 1, 1, 1, 0, 8'hE0, 24'h030201, 2'd3, 16'd0});
    vq.push_back('{0, 0, 1, 8'h05, 1, 1, 1, 0, 8'h05, 24'h000000, 2'd0, 16'd1});
    vq.push_back('{0, 0, 0, 8'h00, 1, 1, 0, 0, 8'h05, 24'h000000, 2'd0, 16'd2});
    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].fl, vq[i].iv, vq[i].d, vq[i].ordy);
      chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vq[i].ir));
      chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vq[i].ov));
      chk($sformatf("v%0d busy", i), 64'(busy), 64'(vq[i].bz));
      chk($sformatf("v%0d opcode", i), 64'(out_opcode), 64'(vq[i].op));
      chk($sformatf("v%0d imm", i), 64'(out_imm), 64'(vq[i].imm));
      chk($sformatf("v%0d imm_count", i), 64'(out_imm_count), 64'(vq[i].cnt));
      chk($sformatf("v%0d retired", i), 64'(retired), 64'(vq[i].ret));
    end
    // MAX_IMM=1: length 7 clamps to one immediate, next byte becomes its own opcode
    step(1, 0, 0, 8'h00, 1);
    chk("m1 reset valid", 64'(out_valid2), 64'd0);
    step(0, 0, 1, 8'hE0, 1);
    chk("m1 busy", 64'(busy2), 64'd1);
    step(0, 0, 1, 8'h55, 1);
    chk("m1 valid", 64'(out_valid2), 64'd1);
    chk("m1 opcode", 64'(out_opcode2), 64'hE0);
    chk("m1 imm0", 64'(out_imm2), 64'h55);
    chk("m1 count", 64'(out_imm_count2), 64'd1);
    step(0, 0, 1, 8'h00, 1);
    chk("m1 next valid", 64'(out_valid2), 64'd1);
    chk("m1 next opcode", 64'(out_opcode2), 64'h00);
    chk("m1 next imm", 64'(out_imm2), 64'h00);
    chk("m1 next count", 64'(out_imm_count2), 64'd0);
    step(0, 0, 0, 8'h00, 1);
    chk("m1 idle", 64'(out_valid2), 64'd0);
    chk("m1 retired", 64'(retired2), 64'd2);
    // CNT_W=4: 16 retires wrap to 0, the 17th gives 1
    step(1, 0, 0, 8'h00, 1);
    chk("wrap reset", 64'(retired3), 64'd0);
    for (int i = 0; i < 17; i++) step(0, 0, 1, 8'h00, 1);
    chk("wrap 16", 64'(retired3), 64'd0);
    step(0, 0, 0, 8'h00, 1);
    chk("wrap 17", 64'(retired3), 64'd1);
    chk("wrap idle", 64'(out_valid3), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instr_assembler.md
INSTR_ASSEMBLER -- requirements
Module: instr_assembler

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of one instruction/immediate byte.
REQ-002 Parameter MAX_IMM, default 3, legal 1..7, SHALL set the maximum number of immediate bytes gathered per instruction.
REQ-003 Parameter LEN_W, default 3, SHALL set the width of the length field, located at opcode bits [DATA_W-1 : DATA_W-LEN_W].
REQ-004 Parameter CNT_W, default 16, SHALL set the width of the retired-instruction counter.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge only.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 flush  in  1  synchronous abandon of any in-progress or held instruction.
REQ-008 in_data  in  DATA_W  byte stream, carrying an opcode followed by its immediates.
REQ-009 in_valid  in  1  in_data is valid.
REQ-010 in_ready  out  1  block accepts in_data this cycle.
REQ-011 out_opcode  out  DATA_W  assembled opcode.
REQ-012 out_imm  out  MAX_IMM*DATA_W  immediate k at bits [k*DATA_W +: DATA_W].
REQ-013 out_imm_count  out  clog2(MAX_IMM+1)  number of valid immediates.
REQ-014 out_valid  out  1  assembled instruction is presented.
REQ-015 out_ready  in  1  downstream consumes the instruction.
REQ-016 busy  out  1  high while gathering immediates (lock status).
REQ-017 retired  out  CNT_W  count of handshaken instructions.

Function
REQ-018 A transfer SHALL occur on any cycle where in_valid && in_ready; a retire SHALL occur on any cycle where out_valid && out_ready.
REQ-019 The FSM SHALL have three states (IDLE, GATHER, HOLD), with out_valid = (state==HOLD) and busy = (state==GATHER), both registered.
REQ-020 in_ready SHALL be 1 in IDLE and GATHER, and SHALL equal out_ready in HOLD.
REQ-021 An opcode transfer (in IDLE, or in HOLD with a same-cycle retire) SHALL latch out_opcode, zero all of out_imm, and compute n = min(length field, MAX_IMM).
REQ-022 If n==0 the FSM SHALL go to HOLD, giving out_valid one cycle after the transfer; otherwise it SHALL go to GATHER with byte index cnt=0.
REQ-023 In GATHER, each transfer SHALL write imm[cnt] and increment cnt; a transfer with cnt==n-1 SHALL move the FSM to HOLD.
REQ-024 In GATHER, cycles without a transfer SHALL hold all state unchanged.
REQ-025 out_imm_count SHALL equal n while in HOLD; immediates not gathered SHALL read 0.
REQ-026 In HOLD, a retire with no transfer SHALL go to IDLE; a retire with a transfer SHALL process the new byte as an opcode per REQ-021/022 with no bubble.
REQ-027 In HOLD without a retire, all outputs SHALL remain stable and in_data SHALL NOT be consumed.
REQ-028 A length field greater than MAX_IMM SHALL be clamped to MAX_IMM; the extra bytes in the stream SHALL then be treated as the following opcodes.
REQ-029 flush SHALL force IDLE and cnt=0 on the next edge, dominating all other events including a same-cycle retire or transfer.
REQ-030 A retire coincident with flush SHALL still increment retired.
REQ-031 in_ready SHALL remain as defined during a flush cycle, but a transfer on that cycle SHALL be discarded.
REQ-032 retired SHALL increment by 1 per retire and SHALL wrap from 2^CNT_W-1 to 0.

Reset
REQ-033 reset SHALL dominate flush and all handshakes.
REQ-034 On reset the block SHALL give state=IDLE, cnt=0, out_opcode=0, out_imm=0, out_imm_count=0, out_valid=0, busy=0, retired=0.
REQ-035 On reset, in_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-036 Reset asserted mid-GATHER or in HOLD SHALL drop the partial or held instruction without a retire.

Verification
REQ-037 Defaults, bytes 0x40,0xAA,0xBB with out_ready=1 -> out_valid one cycle after 0xBB, opcode 0x40, imm0=0xAA, imm1=0xBB, imm2=0, count=2, busy high for exactly 2 cycles.
REQ-038 Back-to-back zero-length opcodes 0x01,0x02,0x03, in_valid and out_ready held at 1 -> in_ready stays 1, three consecutive out_valid cycles, retired=3.
REQ-039 Opcode 0x60 then 0x11,0x22,0x33 with out_ready=0 -> HOLD holds count=3 and in_ready=0 until out_ready rises, then next byte accepted as opcode on the retire cycle.
REQ-040 MAX_IMM=1, opcode 0xE0 followed by 0x55,0x00 -> count=1, imm0=0x55, then 0x00 emitted as a separate zero-length instruction.
REQ-041 flush asserted after 0x60,0x11 -> next cycle busy=0, out_valid=0, and the following byte 0x00 emerges as a zero-length instruction.
REQ-042 CNT_W=4, 17 retires -> retired=1; reset asserted in GATHER -> all REQ-034 values on the next cycle.
